// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO, LSB-first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bits.
module uart_tx #(
  parameter int MAIN_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BD = MAIN_CLK / BAUD;
  localparam int BW = (BD > 1) ? $clog2(BD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       full, empty, push, pop, load, tick;
  logic [7:0] head;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign data_ready = !full && !rst;
  assign push       = data_valid && data_ready;
  assign head       = mem_q[rptr_q];
  assign tick       = (baud_q == BW'(BD - 1));
  assign pop        = load;

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE) || !empty;

  always_comb begin
    state_d  = state_q;
    baud_d   = (state_q == S_IDLE) ? baud_q : (tick ? '0 : baud_q + BW'(1));
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    load     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d     = par_q;
            state_d  = S_PARITY;
`else
            tx_d     = 1'b1;
            state_d  = S_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            tx_d     = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          // Last stop bit: chain straight into the next frame if one is queued
          if (bitcnt_q == 3'(STOP_BITS - 1)) begin
            if (!empty) load = 1'b1;
            else state_d = S_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      shreg_d  = head;
      tx_d     = 1'b0;
      baud_d   = '0;
      bitcnt_d = '0;
      state_d  = S_START;
`ifdef UART_TX_PARITY_EN
      par_d    = ^head;
`endif
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, hand sequences and
// randomized bytes checked by a line-level frame model and decoder.
module tb_uart_tx;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dv;
  logic [7:0] din [2];
  logic [1:0] rdy, txl, bsy;

  always #5 clk = ~clk;

  uart_tx #(
    .MAIN_CLK(16), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_valid(dv[0]), .data(din[0]),
    .data_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0])
  );

  uart_tx #(
    .MAIN_CLK(16), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .data_valid(dv[1]), .data(din[1]),
    .data_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1])
  );

  typedef struct {
    logic [7:0] d;
    bit         par;
    int         sb;
  } vec_t;

  vec_t       tbl [8];
  int         tests = 0;
  int         fails = 0;
  bit         expq [$];
  logic [7:0] gotq [$];
  logic [7:0] expb [$];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add_frame(input logic [7:0] d, input bit p,
                                    input int sb);
    expq.push_back(1'b0);
    for (int i = 0; i < 8; i++) expq.push_back(d[i]);
    if (PAR != 0) expq.push_back(p);
    for (int i = 0; i < sb; i++) expq.push_back(1'b1);
  endfunction

  task automatic send(input int u, input logic [7:0] b,
                      output bit ok, output int waited);
    bit acc;
    din[u] = b;
    dv[u] = 1'b1;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 4000; i++) begin
      acc = rdy[u];
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    dv[u] = 1'b0;
  endtask

  // Called one step after the edge that should launch the start bit.
  task automatic check_wave(input int u, input string nm);
    int n, bad, badk, nb;
    n = expq.size() * BD;
    bad = 0;
    badk = -1;
    nb = 0;
    for (int k = 0; k < n; k++) begin
      if (txl[u] !== expq[k / BD]) begin
        bad++;
        if (badk < 0) badk = k;
      end
      if (bsy[u] !== 1'b1) nb++;
      step(1);
    end
    chk(bad == 0, {nm, " wave (act=first bad cycle)"}, badk, -1);
    chk(nb == 0, {nm, " busy during frame"}, nb, 0);
    chk(bsy[u] === 1'b0 && txl[u] === 1'b1, {nm, " idle after frame"},
        {bsy[u], txl[u]}, 2'b01);
    expq.delete();
  endtask

  task automatic decode(input int u, input int n);
    logic [7:0] b;
    bit found;
    int err;
    for (int f = 0; f < n; f++) begin
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (txl[u] === 1'b0) begin
          found = 1'b1;
          break;
        end
        step(1);
      end
      if (!found) begin
        chk(1'b0, "decode timeout", f, n);
        return;
      end
      err = 0;
      step(BD / 2);
      if (txl[u] !== 1'b0) err++;
      for (int i = 0; i < 8; i++) begin
        step(BD);
        b[i] = txl[u];
      end
      if (PAR != 0) begin
        step(BD);
        if (txl[u] !== ^b) err++;
      end
      for (int i = 0; i < u + 1; i++) begin
        step(BD);
        if (txl[u] !== 1'b1) err++;
      end
      chk(err == 0, "framing", err, 0);
      gotq.push_back(b);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, ok2;
    int w, w2, low, u, blocked_at, ng;
    logic [7:0] b;

    tbl[0] = '{8'h55, 1'b0, 1};
    tbl[1] = '{8'hA5, 1'b0, 1};
    tbl[2] = '{8'h00, 1'b0, 1};
    tbl[3] = '{8'hFF, 1'b0, 1};
    tbl[4] = '{8'h07, 1'b1, 1};
    tbl[5] = '{8'h03, 1'b0, 1};
    tbl[6] = '{8'h80, 1'b1, 2};
    tbl[7] = '{8'h3C, 1'b0, 2};

    rst = 1'b1;
    dv = '0;
    din[0] = '0;
    din[1] = '0;
    step(3);
    chk(txl === 2'b11, "reset tx", txl, 2'b11);
    chk(bsy === 2'b00, "reset busy", bsy, 2'b00);
    chk(rdy === 2'b00, "ready in reset", rdy, 2'b00);
    rst = 1'b0;
    #1;
    chk(rdy === 2'b11, "ready after reset", rdy, 2'b11);
    step(5);
    chk(txl === 2'b11 && bsy === 2'b00, "idle line", {txl, bsy}, 4'b1100);

    for (int i = 0; i < 8; i++) begin
      u = (tbl[i].sb == 2) ? 1 : 0;
      add_frame(tbl[i].d, tbl[i].par, tbl[i].sb);
      send(u, tbl[i].d, ok, w);
      chk(ok && txl[u] === 1'b1 && bsy[u] === 1'b1, "accept edge",
          {ok, txl[u], bsy[u]}, 3'b111);
      step(1);
      check_wave(u, "table frame");
    end

    // Back-to-back: second byte must start the cycle the first stop ends
    add_frame(8'hA5, 1'b0, 1);
    add_frame(8'h3C, 1'b0, 1);
    send(0, 8'hA5, ok, w);
    send(0, 8'h3C, ok2, w2);
    chk(ok && ok2 && w2 == 0, "b2b accept", {ok, ok2}, 2'b11);
    check_wave(0, "b2b");

    // FIFO full: 1 byte in the shifter plus 4 buffered, the 6th must wait
    blocked_at = -1;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          send(0, 8'(i), ok, w);
          if (!ok) chk(1'b0, "full send timeout", i, 0);
          if (w > 0 && blocked_at < 0) blocked_at = i;
        end
      end
      decode(0, 6);
    join
    chk(blocked_at == 6, "first blocked byte", blocked_at, 6);
    chk(gotq.size() == 6, "full count", gotq.size(), 6);
    ng = gotq.size();
    for (int i = 0; i < ng; i++)
      chk(gotq[i] == 8'(i + 1), "full order", gotq[i], i + 1);
    gotq.delete();
    step(3 * BD);

    // Reset in the middle of data bit 3
    send(0, 8'hFF, ok, w);
    send(0, 8'h00, ok2, w2);
    step(4 * BD + 5);
    chk(bsy[0] === 1'b1, "busy before abort", bsy[0], 1);
    rst = 1'b1;
    step(1);
    chk(txl[0] === 1'b1 && bsy[0] === 1'b0 && rdy[0] === 1'b0,
        "abort reset edge", {txl[0], bsy[0], rdy[0]}, 3'b100);
    rst = 1'b0;
    #1;
    chk(rdy[0] === 1'b1, "ready after abort", rdy[0], 1);
    low = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) low++;
    end
    chk(low == 0, "quiet after abort", low, 0);

    // Randomized bytes with random gaps, checked by the line decoder
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          w = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 250)
                                          : $urandom_range(0, 3);
          if (w > 0) step(w);
          b = 8'($urandom);
          send(0, b, ok, w2);
          if (ok) expb.push_back(b);
          else chk(1'b0, "rand send timeout", i, 0);
        end
      end
      decode(0, 24);
    join
    chk(gotq.size() == expb.size(), "rand count", gotq.size(), expb.size());
    ng = (gotq.size() < expb.size()) ? gotq.size() : expb.size();
    for (int i = 0; i < ng; i++)
      chk(gotq[i] == expb[i], "rand byte", gotq[i], expb[i]);
    step(2 * BD);
    chk(bsy[0] === 1'b0 && txl[0] === 1'b1, "rand idle end",
        {bsy[0], txl[0]}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
